hi_reader_pause_detect: RTL and testbench

- Upstream stage of the ISO14443-A FPGA path.
- Turns raw 8-bit ADC samples of the reader's 100% ASK carrier into a clean hysteresis signal, after_hysteresis.
- Times each carrier pause, captures the 16-tick bit phase of each falling edge, and flags pauses of legal length.
- Consumers: the sniffer/tagsim sampling logic (reader_data shift register) and the FDT timer.

---
 rtl/hi_reader_pause_detect_if.sv | 52 +++++
 rtl/hi_reader_pause_detect.sv | 130 +++++++++++++
 tb/tb_hi_reader_pause_detect.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hi_reader_pause_detect_if.sv
// Signal bundle for the reader pause detector: raw ADC sample and bit phase in,
// shaped carrier, edge/pause pulses and pause timing out.
//   adc_d             raw 8-bit ADC sample of the reader carrier
//   bit_phase         16-tick bit phase from the timing block
//   after_hysteresis  shaped carrier (1 = carrier on)
//   falling_edge      one-cycle pulse when the carrier drops
//   falling_edge_time bit_phase captured at the last drop
//   has_been_low_for  periods elapsed since the drop
//   pause_done        one-cycle pulse when a pause ends on threshold
//   pause_len         length of the last completed pause
//   pause_ok          last pause length within the legal window
//   carrier_timeout   one-cycle pulse on a forced release
interface hi_reader_pause_detect_if;
    logic [7:0]  adc_d;
    logic [3:0]  bit_phase;
    logic        after_hysteresis;
    logic        falling_edge;
    logic [3:0]  falling_edge_time;
    logic [11:0] has_been_low_for;
    logic        pause_done;
    logic [11:0] pause_len;
    logic        pause_ok;
    logic        carrier_timeout;

    // Sample source side: drives the ADC sample and phase.
    modport master (
        output adc_d,
        output bit_phase,
        input  after_hysteresis,
        input  falling_edge,
        input  falling_edge_time,
        input  has_been_low_for,
        input  pause_done,
        input  pause_len,
        input  pause_ok,
        input  carrier_timeout
    );

    // Detector side.
    modport slave (
        input  adc_d,
        input  bit_phase,
        output after_hysteresis,
        output falling_edge,
        output falling_edge_time,
        output has_been_low_for,
        output pause_done,
        output pause_len,
        output pause_ok,
        output carrier_timeout
    );
endinterface

// File: rtl/hi_reader_pause_detect.sv
// ISO14443-A reader pause detector: hysteresis shaping of the 100% ASK carrier,
// pause timing, falling-edge phase capture and legal-length flagging.
//   adc_clk  carrier clock, all state updates on its falling edge
//   reset    asynchronous active-high reset
//   bus      slave side of hi_reader_pause_detect_if
module hi_reader_pause_detect #(
    parameter logic [7:0]  HIGH_THRESH = 8'd224,
    parameter logic [7:0]  LOW_THRESH  = 8'd192,
    parameter logic [11:0] TIMEOUT     = 12'd4095,
    parameter logic [11:0] MIN_PAUSE   = 12'd20,
    parameter logic [11:0] MAX_PAUSE   = 12'd60
) (
    input  logic                    adc_clk,
    input  logic                    reset,
    hi_reader_pause_detect_if.slave bus
);

    // The shaped carrier level is the state itself.
    typedef enum logic {
        ST_HIGH = 1'b0,
        ST_LOW  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  fet_q, fet_d;
    logic [11:0] plen_q, plen_d;
    logic        pok_q, pok_d;
    logic        fe_q, fe_d;
    logic        pd_q, pd_d;
    logic        to_q, to_d;

    logic        high_hit;
    logic        low_hit;
    logic [11:0] len_next;

    assign high_hit = (bus.adc_d >= HIGH_THRESH);
    assign low_hit  = (bus.adc_d <= LOW_THRESH);

    // Only used when not timing out, so cnt_q < TIMEOUT and no wrap occurs.
    assign len_next = cnt_q + 12'd1;

    always_ff @(negedge adc_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HIGH;
            cnt_q   <= 12'd0;
            fet_q   <= 4'd0;
            plen_q  <= 12'd0;
            pok_q   <= 1'b0;
            fe_q    <= 1'b0;
            pd_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fet_q   <= fet_d;
            plen_q  <= plen_d;
            pok_q   <= pok_d;
            fe_q    <= fe_d;
            pd_q    <= pd_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fet_d   = fet_q;
        plen_d  = plen_q;
        pok_d   = pok_q;
        fe_d    = 1'b0;
        pd_d    = 1'b0;
        to_d    = 1'b0;

        unique case (state_q)
            ST_HIGH: begin
                cnt_d = 12'd0;
                // high_hit wins over low_hit; with LOW < HIGH they never overlap.
                if (!high_hit && low_hit) begin
                    state_d = ST_LOW;
                    fe_d    = 1'b1;
                    fet_d   = bus.bit_phase;
                end
            end
            ST_LOW: begin
                if (cnt_q == TIMEOUT) begin
                    // Forced release ignores the sample on this edge.
                    state_d = ST_HIGH;
                    cnt_d   = 12'd0;
                    to_d    = 1'b1;
                end else if (high_hit) begin
                    state_d = ST_HIGH;
                    cnt_d   = 12'd0;
                    pd_d    = 1'b1;
                    plen_d  = len_next;
                    pok_d   = (len_next >= MIN_PAUSE) &&
                              (len_next <= MAX_PAUSE);
                end else begin
                    // Samples inside the band hold the low level.
                    cnt_d = len_next;
                end
            end
            default: begin
                state_d = ST_HIGH;
                cnt_d   = 12'd0;
            end
        endcase
    end

    assign bus.after_hysteresis  = (state_q == ST_HIGH);
    assign bus.falling_edge      = fe_q;
    assign bus.falling_edge_time = fet_q;
    assign bus.has_been_low_for  = cnt_q;
    assign bus.pause_done        = pd_q;
    assign bus.pause_len         = plen_q;
    assign bus.pause_ok          = pok_q;
    assign bus.carrier_timeout   = to_q;

    // Structural invariants of the pulse outputs and counter.
    a_pulses_exclusive: assert property (
        @(negedge adc_clk) disable iff (reset)
        $onehot0({fe_q, pd_q, to_q})
    );

    a_cnt_zero_high: assert property (
        @(negedge adc_clk) disable iff (reset)
        (state_q == ST_HIGH) |-> (cnt_q == 12'd0)
    );

endmodule

// File: tb/tb_hi_reader_pause_detect.sv
// Scoreboard bench for hi_reader_pause_detect: directed sample streams push
// expected pulses; a monitor pops and compares on every pulse cycle.
module tb_hi_reader_pause_detect;

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  fet;
        logic [11:0] plen;
        logic        pok;
    } ev_t;

    localparam logic [2:0] K_FE = 3'b100;
    localparam logic [2:0] K_PD = 3'b010;
    localparam logic [2:0] K_TO = 3'b001;

    logic adc_clk = 1'b0;
    logic reset   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    ev_t  exp_q[$];

    hi_reader_pause_detect_if bus ();

    hi_reader_pause_detect dut (
        .adc_clk (adc_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 adc_clk = ~adc_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0d req=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [3:0] f,
                        input logic [11:0] l, input logic o);
        ev_t e;
        e.kind = k;
        e.fet  = f;
        e.plen = l;
        e.pok  = o;
        exp_q.push_back(e);
    endtask

    // Drive a sample; return at the posedge after the DUT has consumed it.
    task automatic step(input logic [7:0] d, input logic [3:0] ph);
        bus.adc_d     = d;
        bus.bit_phase = ph;
        @(posedge adc_clk);
    endtask

    task automatic pause(input int n, input logic [3:0] ph,
                         input logic [11:0] len, input logic ok);
        push(K_FE, ph, 12'd0, 1'b0);
        step(8'd10, ph);
        chk("drop_ah", 32'(bus.after_hysteresis), 0);
        chk("drop_cnt", 32'(bus.has_been_low_for), 0);
        for (int k = 1; k < n; k++) begin
            step(8'd10, ph ^ 4'hf);
            chk("low_cnt", 32'(bus.has_been_low_for), 32'(k));
        end
        push(K_PD, 4'd0, len, ok);
        step(8'd250, 4'd0);
        chk("rise_ah", 32'(bus.after_hysteresis), 1);
        chk("rise_cnt", 32'(bus.has_been_low_for), 0);
        chk("fet_hold", 32'(bus.falling_edge_time), 32'(ph));
        step(8'd250, 4'd0);
    endtask

    always @(posedge adc_clk) begin
        logic [2:0] act;
        ev_t        e;
        act = {bus.falling_edge, bus.pause_done, bus.carrier_timeout};
        if (!reset && act != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(act), 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", 32'(act), 32'(e.kind));
                if (e.kind == K_FE)
                    chk("fe_time", 32'(bus.falling_edge_time), 32'(e.fet));
                if (e.kind == K_PD || e.kind == K_TO) begin
                    chk("pause_len", 32'(bus.pause_len), 32'(e.plen));
                    chk("pause_ok", 32'(bus.pause_ok), 32'(e.pok));
                end
            end
        end
    end

    initial begin
        bus.adc_d     = 8'd250;
        bus.bit_phase = 4'd0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ah", 32'(bus.after_hysteresis), 1);
        chk("rst_cnt", 32'(bus.has_been_low_for), 0);
        chk("rst_plen", 32'(bus.pause_len), 0);
        chk("rst_fet", 32'(bus.falling_edge_time), 0);
        chk("rst_pok", 32'(bus.pause_ok), 0);
        chk("rst_pulses", 32'({bus.falling_edge, bus.pause_done,
                               bus.carrier_timeout}), 0);
        @(posedge adc_clk);
        @(posedge adc_clk);
        #1 reset = 1'b0;

        // Steady carrier.
        for (int i = 0; i < 10; i++) begin
            step(8'd250, 4'(i));
            chk("idle_ah", 32'(bus.after_hysteresis), 1);
            chk("idle_cnt", 32'(bus.has_been_low_for), 0);
        end

        // 30-period pause captured at phase 9.
        pause(30, 4'd9, 12'd30, 1'b1);

        // Hysteresis band while high, then while low.
        for (int i = 0; i < 8; i++) begin
            step((i % 2 == 0) ? 8'd200 : 8'd210, 4'd1);
            chk("band_hi_ah", 32'(bus.after_hysteresis), 1);
        end
        push(K_FE, 4'd2, 12'd0, 1'b0);
        step(8'd192, 4'd2);
        chk("at_low_ah", 32'(bus.after_hysteresis), 0);
        for (int i = 0; i < 8; i++) begin
            step((i % 2 == 0) ? 8'd200 : 8'd210, 4'd4);
            chk("band_lo_ah", 32'(bus.after_hysteresis), 0);
            chk("band_lo_cnt", 32'(bus.has_been_low_for), 32'(i + 1));
        end
        step(8'd223, 4'd4);
        chk("below_hi_ah", 32'(bus.after_hysteresis), 0);
        push(K_PD, 4'd0, 12'd10, 1'b0);
        step(8'd224, 4'd4);
        chk("at_hi_ah", 32'(bus.after_hysteresis), 1);
        step(8'd250, 4'd0);

        // Pause length window boundaries.
        pause(19, 4'd3, 12'd19, 1'b0);
        pause(61, 4'd12, 12'd61, 1'b0);
        pause(20, 4'd0, 12'd20, 1'b1);
        pause(60, 4'd15, 12'd60, 1'b1);

        // Stuck-low carrier: forced release, then a fresh drop.
        for (int k = 0; k < 5000; k++) begin
            if (k == 0 || k == 4097) push(K_FE, 4'd5, 12'd0, 1'b0);
            if (k == 4096) push(K_TO, 4'd0, 12'd60, 1'b1);
            step(8'd0, 4'd5);
            if (k == 4095) begin
                chk("to_pre_ah", 32'(bus.after_hysteresis), 0);
                chk("to_pre_cnt", 32'(bus.has_been_low_for), 4095);
            end
            if (k == 4096) begin
                chk("to_ah", 32'(bus.after_hysteresis), 1);
                chk("to_cnt", 32'(bus.has_been_low_for), 0);
            end
            if (k == 4097) begin
                chk("to_redrop_ah", 32'(bus.after_hysteresis), 0);
                chk("to_redrop_cnt", 32'(bus.has_been_low_for), 0);
            end
        end
        chk("stuck_cnt", 32'(bus.has_been_low_for), 902);
        push(K_PD, 4'd0, 12'd903, 1'b0);
        step(8'd250, 4'd0);
        chk("stuck_rise_ah", 32'(bus.after_hysteresis), 1);
        step(8'd250, 4'd0);

        // Reset asserted mid-pause.
        push(K_FE, 4'd7, 12'd0, 1'b0);
        step(8'd10, 4'd7);
        for (int k = 1; k < 16; k++) step(8'd10, 4'd0);
        chk("mid_cnt", 32'(bus.has_been_low_for), 15);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ah", 32'(bus.after_hysteresis), 1);
        chk("mid_rst_cnt", 32'(bus.has_been_low_for), 0);
        chk("mid_rst_fet", 32'(bus.falling_edge_time), 0);
        chk("mid_rst_plen", 32'(bus.pause_len), 0);
        chk("mid_rst_pok", 32'(bus.pause_ok), 0);
        @(posedge adc_clk);
        bus.adc_d = 8'd250;
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(8'd250, 4'd0);
            chk("post_rst_ah", 32'(bus.after_hysteresis), 1);
            chk("post_rst_cnt", 32'(bus.has_been_low_for), 0);
        end

        step(8'd250, 4'd0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
